// File: rtl/dest_match_pkg.sv
// Shared types and helpers for the destination-ID match arbiter.
package dest_match_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COMPARE = 2'd1,
    RESPOND = 2'd2
  } state_e;

  // All-ones ID of the given width, returned in a 64-bit container.
  function automatic logic [63:0] BCAST_ID(input int unsigned width);
    if (width >= 64) begin
      return '1;
    end
    return (64'd1 << width) - 64'd1;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: first requester at or after the pointer wins.
module rr_arbiter #(
  parameter int unsigned NUM_CH = 4,
  localparam int unsigned CH_W  = $clog2(NUM_CH)
) (
  input  logic [NUM_CH-1:0] i_req,
  input  logic [CH_W-1:0]   i_ptr,
  output logic [NUM_CH-1:0] o_gnt,
  output logic [CH_W-1:0]   o_idx,
  output logic              o_valid
);

  int unsigned w_idx;

  always_comb begin
    o_gnt   = '0;
    o_idx   = '0;
    o_valid = 1'b0;
    w_idx   = 0;
    for (int unsigned off = 0; off < NUM_CH; off++) begin
      w_idx = (32'(i_ptr) + off) % NUM_CH;
      if (!o_valid && i_req[w_idx]) begin
        o_valid      = 1'b1;
        o_gnt[w_idx] = 1'b1;
        o_idx        = CH_W'(w_idx);
      end
    end
  end

endmodule

// File: rtl/dest_match_arb.sv
// Multi-channel destination-ID checker with round-robin arbitration and saturating stats.
// Optional broadcast detection is enabled by defining DEST_BROADCAST_EN.
module dest_match_arb
  import dest_match_pkg::*;
#(
  parameter int unsigned ID_W    = 16,
  parameter int unsigned NUM_CH  = 4,
  parameter int unsigned COUNT_W = 16,
  localparam int unsigned CH_W   = $clog2(NUM_CH)
) (
  input  logic                   i_clock,
  input  logic                   i_rst,
  input  logic                   i_en,
  input  logic [ID_W-1:0]        i_my_node_id,
  input  logic [ID_W-1:0]        i_my_node_mask,
  input  logic [NUM_CH-1:0]      i_req_valid,
  input  logic [NUM_CH*ID_W-1:0] i_req_dest_id,
  output logic [NUM_CH-1:0]      o_req_ready,
  output logic                   o_res_valid,
  input  logic                   i_res_ready,
  output logic [CH_W-1:0]        o_res_ch,
  output logic                   o_iamDestination,
  output logic                   o_is_broadcast,
  output logic                   o_done,
  input  logic                   i_clear_counts,
  output logic [COUNT_W-1:0]     o_match_count,
  output logic [COUNT_W-1:0]     o_reject_count
);

  state_e               r_state;
  logic [CH_W-1:0]      r_rr_ptr;
  logic [CH_W-1:0]      r_gnt_idx;
  logic [ID_W-1:0]      r_dest;
  logic                 r_res_valid;
  logic [CH_W-1:0]      r_res_ch;
  logic                 r_iam;
  logic                 r_bcast;
  logic                 r_done;
  logic [COUNT_W-1:0]   r_match_cnt;
  logic [COUNT_W-1:0]   r_reject_cnt;

  logic [NUM_CH-1:0]    w_gnt;
  logic [CH_W-1:0]      w_gnt_idx;
  logic                 w_arb_valid;
  logic [CH_W-1:0]      w_next_ptr;
  logic                 w_match_raw;
  logic                 w_is_bcast;
  logic                 w_match;

  rr_arbiter #(
    .NUM_CH (NUM_CH)
  ) u_rr_arbiter (
    .i_req   (i_req_valid),
    .i_ptr   (r_rr_ptr),
    .o_gnt   (w_gnt),
    .o_idx   (w_gnt_idx),
    .o_valid (w_arb_valid)
  );

  assign w_next_ptr  = (w_gnt_idx == CH_W'(NUM_CH - 1)) ? '0 : w_gnt_idx + CH_W'(1);
  assign w_match_raw = ((r_dest ^ i_my_node_id) & i_my_node_mask) == '0;

`ifdef DEST_BROADCAST_EN
  logic [ID_W-1:0] w_bcast_id;
  assign w_bcast_id = ID_W'(BCAST_ID(ID_W));
  assign w_is_bcast = (r_dest == w_bcast_id);
  assign w_match    = w_match_raw | w_is_bcast;
`else
  assign w_is_bcast = 1'b0;
  assign w_match    = w_match_raw;
`endif

  // Grant strobe is combinational so the requester sees it in the accepting cycle.
  assign o_req_ready = (r_state == IDLE && i_en) ? w_gnt : '0;

  always_ff @(posedge i_clock) begin
    if (i_rst) begin
      r_state     <= IDLE;
      r_rr_ptr    <= '0;
      r_gnt_idx   <= '0;
      r_dest      <= '0;
      r_res_valid <= 1'b0;
      r_res_ch    <= '0;
      r_iam       <= 1'b0;
      r_bcast     <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      r_done <= 1'b0;
      unique case (r_state)
        IDLE: begin
          if (i_en && w_arb_valid) begin
            r_dest    <= i_req_dest_id[w_gnt_idx*ID_W +: ID_W];
            r_gnt_idx <= w_gnt_idx;
            r_rr_ptr  <= w_next_ptr;
            r_state   <= COMPARE;
          end
        end
        COMPARE: begin
          r_iam       <= w_match;
          r_bcast     <= w_is_bcast;
          r_res_ch    <= r_gnt_idx;
          r_res_valid <= 1'b1;
          r_state     <= RESPOND;
        end
        RESPOND: begin
          if (i_res_ready) begin
            r_res_valid <= 1'b0;
            r_done      <= 1'b1;
            r_state     <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  // Clear takes priority over an increment landing in the same cycle.
  always_ff @(posedge i_clock) begin
    if (i_rst || i_clear_counts) begin
      r_match_cnt  <= '0;
      r_reject_cnt <= '0;
    end else if (r_state == COMPARE) begin
      if (w_match) begin
        if (r_match_cnt != '1) r_match_cnt <= r_match_cnt + COUNT_W'(1);
      end else begin
        if (r_reject_cnt != '1) r_reject_cnt <= r_reject_cnt + COUNT_W'(1);
      end
    end
  end

  assign o_res_valid      = r_res_valid;
  assign o_res_ch         = r_res_ch;
  assign o_iamDestination = r_iam;
  assign o_is_broadcast   = r_bcast;
  assign o_done           = r_done;
  assign o_match_count    = r_match_cnt;
  assign o_reject_count   = r_reject_cnt;

endmodule

// File: tb/tb_dest_match_arb.sv
// Scoreboard bench for dest_match_arb (NUM_CH=4, ID_W=16, COUNT_W=2); honours DEST_BROADCAST_EN.
module tb_dest_match_arb;

  logic        clk;
  logic        rst;
  logic        en;
  logic [15:0] my_id;
  logic [15:0] my_mask;
  logic [3:0]  req_valid;
  logic [63:0] req_dest_id;
  logic [3:0]  req_ready;
  logic        res_valid;
  logic        res_ready;
  logic [1:0]  res_ch;
  logic        iam;
  logic        bcast;
  logic        done;
  logic        clear;
  logic [1:0]  mcnt;
  logic [1:0]  rcnt;

  logic [15:0] dest_arr [4];

  typedef struct {
    logic [1:0] ch;
    logic       iam;
    logic       bc;
  } exp_t;

  exp_t sb[$];
  int   checks   = 0;
  int   failures = 0;
  int   em       = 0;
  int   er       = 0;

  dest_match_arb #(
    .ID_W    (16),
    .NUM_CH  (4),
    .COUNT_W (2)
  ) dut (
    .i_clock          (clk),
    .i_rst            (rst),
    .i_en             (en),
    .i_my_node_id     (my_id),
    .i_my_node_mask   (my_mask),
    .i_req_valid      (req_valid),
    .i_req_dest_id    (req_dest_id),
    .o_req_ready      (req_ready),
    .o_res_valid      (res_valid),
    .i_res_ready      (res_ready),
    .o_res_ch         (res_ch),
    .o_iamDestination (iam),
    .o_is_broadcast   (bcast),
    .o_done           (done),
    .i_clear_counts   (clear),
    .o_match_count    (mcnt),
    .o_reject_count   (rcnt)
  );

  always #5 clk = ~clk;

  always_comb begin
    req_dest_id = '0;
    for (int c = 0; c < 4; c++) req_dest_id[c*16 +: 16] = dest_arr[c];
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic timeout_fail(input string name);
    checks++;
    failures++;
    $display("FAIL %s: timed out at %0t", name, $time);
  endtask

  task automatic upd(input logic m);
    if (m) begin
      if (em < 3) em++;
    end else begin
      if (er < 3) er++;
    end
  endtask

  // Monitor: pops one expectation per completed result handshake.
  always @(negedge clk) begin
    if (!rst && res_valid && res_ready) begin
      if (sb.size() == 0) begin
        timeout_fail("sb_unexpected_result");
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("res_ch", 64'(res_ch), 64'(e.ch));
        chk("iam", 64'(iam), 64'(e.iam));
        chk("is_bcast", 64'(bcast), 64'(e.bc));
      end
    end
  end

  task automatic wait_grant(output bit ok);
    ok = 1'b0;
    for (int n = 0; n < 20; n++) begin
      if (req_ready != 4'b0) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
      #1;
    end
    if (!ok) timeout_fail("grant_wait");
  endtask

  task automatic wait_done(output bit ok);
    ok = 1'b0;
    for (int n = 0; n < 20; n++) begin
      @(negedge clk);
      if (done) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) timeout_fail("done_wait");
  endtask

  // mode: 0 plain, 1 latency check, 2 clear during COMPARE, 3 drop en in flight
  task automatic issue(input int ch, input logic [15:0] d, input logic exp_iam,
                       input logic exp_bc, input int mode);
    bit   ok;
    exp_t e;
    dest_arr[ch]  = d;
    req_valid[ch] = 1'b1;
    #1;
    wait_grant(ok);
    if (!ok) begin
      req_valid[ch] = 1'b0;
      return;
    end
    chk("grant", 64'(req_ready), 64'(1) << ch);
    e.ch  = 2'(ch);
    e.iam = exp_iam;
    e.bc  = exp_bc;
    sb.push_back(e);
    @(posedge clk);
    #1;
    req_valid[ch] = 1'b0;
    if (mode == 2) begin
      clear = 1'b1;
      em = 0;
      er = 0;
      @(posedge clk);
      #1;
      clear = 1'b0;
    end else begin
      upd(exp_iam);
    end
    if (mode == 3) en = 1'b0;
    if (mode == 1) begin
      @(negedge clk);
      chk("lat_t1_valid", 64'(res_valid), 64'(0));
      @(negedge clk);
      chk("lat_t2_valid", 64'(res_valid), 64'(1));
    end
    wait_done(ok);
    en = 1'b1;
    chk("match_count", 64'(mcnt), 64'(em));
    chk("reject_count", 64'(rcnt), 64'(er));
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    em = 0;
    er = 0;
    sb.delete();
  endtask

  logic [15:0] rr_d   [4];
  logic        rr_iam [4];

  initial begin
    bit ok;
    clk       = 1'b0;
    rst       = 1'b1;
    en        = 1'b1;
    res_ready = 1'b1;
    clear     = 1'b0;
    req_valid = 4'b0;
    my_id     = 16'h0;
    my_mask   = 16'h0;
    for (int c = 0; c < 4; c++) dest_arr[c] = 16'h0;
    rr_d   = '{16'h00A5, 16'h0000, 16'h00A5, 16'h1111};
    rr_iam = '{1'b1, 1'b0, 1'b1, 1'b0};

    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk("rst_req_ready", 64'(req_ready), 64'(0));
    chk("rst_res_valid", 64'(res_valid), 64'(0));
    chk("rst_res_ch", 64'(res_ch), 64'(0));
    chk("rst_iam", 64'(iam), 64'(0));
    chk("rst_bcast", 64'(bcast), 64'(0));
    chk("rst_done", 64'(done), 64'(0));
    chk("rst_mcnt", 64'(mcnt), 64'(0));
    chk("rst_rcnt", 64'(rcnt), 64'(0));

    // Single match on channel 2 with latency check
    my_id   = 16'h00A5;
    my_mask = 16'hFFFF;
    issue(2, 16'h00A5, 1'b1, 1'b0, 1);

    // Masked compare: high byte only
    my_id   = 16'h1234;
    my_mask = 16'hFF00;
    issue(0, 16'h12FF, 1'b1, 1'b0, 0);
    issue(1, 16'h13FF, 1'b0, 1'b0, 0);

    // Zero mask matches anything; en dropped while in flight
    my_mask = 16'h0000;
    issue(3, 16'h5A5A, 1'b1, 1'b0, 3);

    // Broadcast ID
    my_id   = 16'h0001;
    my_mask = 16'hFFFF;
`ifdef DEST_BROADCAST_EN
    issue(0, 16'hFFFF, 1'b1, 1'b1, 0);
`else
    issue(0, 16'hFFFF, 1'b0, 1'b0, 0);
`endif

    // Clear during COMPARE beats the increment
    issue(1, 16'h0001, 1'b1, 1'b0, 2);

    // Enable low blocks new grants
    @(negedge clk);
    en           = 1'b0;
    dest_arr[1]  = 16'h0001;
    req_valid[1] = 1'b1;
    repeat (4) begin
      @(negedge clk);
      chk("en_block_ready", 64'(req_ready), 64'(0));
    end
    chk("en_block_valid", 64'(res_valid), 64'(0));
    en = 1'b1;
    issue(1, 16'h0001, 1'b1, 1'b0, 0);

    // Round robin with all channels valid; first result stalled 5 cycles
    do_reset();
    my_id   = 16'h00A5;
    my_mask = 16'hFFFF;
    for (int c = 0; c < 4; c++) dest_arr[c] = rr_d[c];
    res_ready = 1'b0;
    req_valid = 4'hF;
    #1;
    for (int k = 0; k < 5; k++) begin
      int   ch;
      exp_t e;
      ch = k % 4;
      wait_grant(ok);
      if (!ok) break;
      chk("rr_grant", 64'(req_ready), 64'(1) << ch);
      e.ch  = 2'(ch);
      e.iam = rr_iam[ch];
      e.bc  = 1'b0;
      sb.push_back(e);
      @(posedge clk);
      #1;
      upd(rr_iam[ch]);
      if (k == 1) chk("done_one_cycle", 64'(done), 64'(0));
      if (k == 4) req_valid = 4'b0;
      if (k == 0) begin
        ok = 1'b0;
        for (int n = 0; n < 10; n++) begin
          @(negedge clk);
          if (res_valid) begin
            ok = 1'b1;
            break;
          end
        end
        if (!ok) timeout_fail("rr_res_valid_wait");
        repeat (5) begin
          @(negedge clk);
          chk("stall_valid", 64'(res_valid), 64'(1));
          chk("stall_ch", 64'(res_ch), 64'(0));
          chk("stall_iam", 64'(iam), 64'(1));
          chk("stall_done", 64'(done), 64'(0));
        end
        @(posedge clk);
        #1;
        res_ready = 1'b1;
      end
      wait_done(ok);
      chk("rr_match_count", 64'(mcnt), 64'(em));
      chk("rr_reject_count", 64'(rcnt), 64'(er));
    end

    // Two more matches: five in total, counter saturates at 3
    issue(1, 16'h00A5, 1'b1, 1'b0, 0);
    issue(2, 16'h00A5, 1'b1, 1'b0, 0);
    chk("sat_match_count", 64'(mcnt), 64'(3));

    // Reset while in RESPOND drops the result with no done pulse
    res_ready   = 1'b0;
    dest_arr[2] = 16'h00A5;
    req_valid[2] = 1'b1;
    #1;
    wait_grant(ok);
    @(posedge clk);
    #1;
    req_valid[2] = 1'b0;
    ok = 1'b0;
    for (int n = 0; n < 10; n++) begin
      @(negedge clk);
      if (res_valid) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) timeout_fail("rst_resp_wait");
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    em = 0;
    er = 0;
    @(negedge clk);
    chk("rst_resp_valid", 64'(res_valid), 64'(0));
    chk("rst_resp_done", 64'(done), 64'(0));
    chk("rst_resp_ch", 64'(res_ch), 64'(0));
    chk("rst_resp_mcnt", 64'(mcnt), 64'(0));
    repeat (3) begin
      @(negedge clk);
      chk("rst_no_done", 64'(done), 64'(0));
    end
    res_ready = 1'b1;

    chk("sb_drained", 64'(sb.size()), 64'(0));
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
